// File: rtl/z_piso_32.sv
// rtl/z_piso_32.sv - parallel-in serial-out transmitter with valid/ready load and valid/last framing
//
// Purpose: accepts a WIDTH-bit word over a valid/ready handshake and shifts it
// out one bit per enabled clock. Back-to-back words are sent with no idle gap.
// A global clock enable freezes all state.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   ena         clock enable; low = every register holds, no handshake completes
//   load_valid  producer has a word on load_data
//   load_data   parallel word, sampled only on an accepted load
//   load_ready  block can accept a word this cycle (combinational from state/cnt)
//   sout        serial data bit
//   sout_valid  sout carries a live bit
//   sout_last   current bit is the final bit of the word
//   busy        FSM is in SHIFT
module z_piso_32 #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept;
  logic             at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    at_last    = (state == SHIFT) && (cnt == LAST);
    // Ready on the final bit as well, so the next word follows without a bubble.
    load_ready = (state == IDLE) || at_last;
    accept     = ena && load_valid && load_ready;

    if (ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg_n = load_data;
            cnt_n   = '0;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (!at_last) begin
            if (LSB_FIRST) shreg_n = {1'b0, shreg[WIDTH-1:1]};
            else           shreg_n = {shreg[WIDTH-2:0], 1'b0};
            cnt_n = cnt + CW'(1);
          end else if (accept) begin
            shreg_n = load_data;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output bit is forced to 0 outside SHIFT so an idle line reads low.
  assign sout       = (state == SHIFT) && (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign sout_valid = (state == SHIFT);
  assign sout_last  = at_last;
  assign busy       = (state == SHIFT);

endmodule
